// File: rtl/rob_commit_pkg.sv
// Shared constants and entry layout for the reorder buffer and its rename table.
package rob_commit_pkg;

    localparam int unsigned ROB_WIDTH_BIT_DEF = 3;
    localparam int unsigned ROB_ENTRIES_DEF   = 2 ** ROB_WIDTH_BIT_DEF;
    localparam int unsigned REG_ID_W          = 5;
    localparam int unsigned NUM_ARCH_REGS     = 2 ** REG_ID_W;
    localparam int unsigned DATA_W            = 32;

    typedef struct packed {
        logic                busy;
        logic                ready;
        logic [REG_ID_W-1:0] rd;
        logic [DATA_W-1:0]   val;
    } rob_entry_t;

endpackage

// File: rtl/rename_table.sv
// Architectural-register rename table: which registers wait on an in-flight ROB entry.
module rename_table
    import rob_commit_pkg::*;
#(
    parameter int unsigned ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [REG_ID_W-1:0]      alloc_rd,
    input  logic [ROB_WIDTH_BIT-1:0] alloc_tag,
    input  logic                     commit_en,
    input  logic [REG_ID_W-1:0]      commit_rd,
    input  logic [ROB_WIDTH_BIT-1:0] commit_tag,
    input  logic [REG_ID_W-1:0]      get_id1,
    input  logic [REG_ID_W-1:0]      get_id2,
    output logic                     has_dep1,
    output logic                     has_dep2,
    output logic [ROB_WIDTH_BIT-1:0] dep1,
    output logic [ROB_WIDTH_BIT-1:0] dep2
);

    typedef logic [ROB_WIDTH_BIT-1:0] tag_t;

    logic [NUM_ARCH_REGS-1:0] has_dep_q, has_dep_d;
    tag_t                     dep_q [NUM_ARCH_REGS];
    tag_t                     dep_d [NUM_ARCH_REGS];

    always_comb begin
        has_dep_d = has_dep_q;
        dep_d     = dep_q;
        if (flush) begin
            has_dep_d = '0;
        end else begin
            // Only the youngest writer of rd releases the dependency.
            if (commit_en && has_dep_q[commit_rd] && (dep_q[commit_rd] == commit_tag)) begin
                has_dep_d[commit_rd] = 1'b0;
            end
            if (alloc_en && (alloc_rd != '0)) begin
                has_dep_d[alloc_rd] = 1'b1;
                dep_d[alloc_rd]     = alloc_tag;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            has_dep_q <= '0;
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                dep_q[i] <= '0;
            end
        end else begin
            has_dep_q <= has_dep_d;
            dep_q     <= dep_d;
        end
    end

    assign has_dep1 = has_dep_q[get_id1];
    assign has_dep2 = has_dep_q[get_id2];
    assign dep1     = dep_q[get_id1];
    assign dep2     = dep_q[get_id2];

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer with single-entry commit into the register file.
// Optional ROB_BYPASS_EN adds operand forwarding from in-flight entries.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int unsigned ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     alloc_valid,
    input  logic [REG_ID_W-1:0]      alloc_rd,
    output logic                     alloc_ready,
    output logic [ROB_WIDTH_BIT-1:0] alloc_id,
    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_id,
    input  logic [DATA_W-1:0]        wb_val,
    output logic [REG_ID_W-1:0]      set_reg_id,
    output logic [DATA_W-1:0]        set_val,
    input  logic [REG_ID_W-1:0]      get_id1,
    input  logic [REG_ID_W-1:0]      get_id2,
    output logic                     get_has_dep1,
    output logic                     get_has_dep2,
    output logic [ROB_WIDTH_BIT-1:0] get_dep1,
    output logic [ROB_WIDTH_BIT-1:0] get_dep2
`ifdef ROB_BYPASS_EN
    ,
    output logic                     get_rdy1,
    output logic                     get_rdy2,
    output logic [DATA_W-1:0]        get_fwd1,
    output logic [DATA_W-1:0]        get_fwd2
`endif
);

    localparam int unsigned             Depth = 2 ** ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0]  Full  = (ROB_WIDTH_BIT + 1)'(Depth);

    typedef logic [ROB_WIDTH_BIT-1:0] idx_t;

    rob_entry_t             rob_q [Depth];
    rob_entry_t             rob_d [Depth];
    idx_t                   head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH_BIT:0] count_q, count_d;
    logic [REG_ID_W-1:0]    set_reg_id_q, set_reg_id_d;
    logic [DATA_W-1:0]      set_val_q, set_val_d;
    rob_entry_t             head_entry;
    logic                   active, flush_act, alloc_fire, commit_fire;

    assign active      = rdy_in && !flush_in;
    assign flush_act   = rdy_in && flush_in;
    assign alloc_ready = count_q < Full;
    assign alloc_id    = tail_q;
    assign head_entry  = rob_q[head_q];
    assign alloc_fire  = active && alloc_valid && alloc_ready;
    assign commit_fire = active && head_entry.busy && head_entry.ready;

    always_comb begin
        rob_d        = rob_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        set_reg_id_d = '0;
        set_val_d    = set_val_q;
        if (flush_act) begin
            for (int i = 0; i < Depth; i++) begin
                rob_d[i].busy = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (active) begin
            if (wb_valid && rob_q[wb_id].busy) begin
                rob_d[wb_id].ready = 1'b1;
                rob_d[wb_id].val   = wb_val;
            end
            if (commit_fire) begin
                rob_d[head_q].busy = 1'b0;
                head_d             = head_q + 1'b1;
                set_reg_id_d       = head_entry.rd;
                set_val_d          = head_entry.val;
            end
            // Tail is never the committing head here: alloc is refused when full.
            if (alloc_fire) begin
                rob_d[tail_q].busy  = 1'b1;
                rob_d[tail_q].ready = 1'b0;
                rob_d[tail_q].rd    = alloc_rd;
                tail_d              = tail_q + 1'b1;
            end
            unique case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < Depth; i++) begin
                rob_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            set_reg_id_q <= '0;
            set_val_q    <= '0;
        end else begin
            rob_q        <= rob_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            set_reg_id_q <= set_reg_id_d;
            set_val_q    <= set_val_d;
        end
    end

    assign set_reg_id = set_reg_id_q;
    assign set_val    = set_val_q;

    rename_table #(
        .ROB_WIDTH_BIT (ROB_WIDTH_BIT)
    ) u_rename_table (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .flush      (flush_act),
        .alloc_en   (alloc_fire),
        .alloc_rd   (alloc_rd),
        .alloc_tag  (tail_q),
        .commit_en  (commit_fire),
        .commit_rd  (head_entry.rd),
        .commit_tag (head_q),
        .get_id1    (get_id1),
        .get_id2    (get_id2),
        .has_dep1   (get_has_dep1),
        .has_dep2   (get_has_dep2),
        .dep1       (get_dep1),
        .dep2       (get_dep2)
    );

`ifdef ROB_BYPASS_EN
    assign get_rdy1 = rob_q[get_dep1].ready;
    assign get_rdy2 = rob_q[get_dep2].ready;
    assign get_fwd1 = rob_q[get_dep1].val;
    assign get_fwd2 = rob_q[get_dep2].val;
`endif

endmodule
